// File: rtl/car_alarm_annunciator_if.sv
// Signal bundle between the alarm detector / driver controls and the annunciator.
interface car_alarm_annunciator_if;
    logic       CarAlarmSignal;
    logic       SilenceButton;
    logic       BuzzerOut;
    logic       WarningLamp;
    logic       AlarmActive;
    logic [3:0] BeepCount;

    modport master (
        output CarAlarmSignal,
        output SilenceButton,
        input  BuzzerOut,
        input  WarningLamp,
        input  AlarmActive,
        input  BeepCount
    );

    modport slave (
        input  CarAlarmSignal,
        input  SilenceButton,
        output BuzzerOut,
        output WarningLamp,
        output AlarmActive,
        output BeepCount
    );
endinterface

// File: rtl/car_alarm_annunciator.sv
// Debounced car alarm annunciator: beeps a fixed number of times, then holds the lamp on
// until the alarm request drops. Outputs are decoded from registered state only.
module car_alarm_annunciator #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned BEEP_ON_CYCLES  = 8,
    parameter int unsigned BEEP_OFF_CYCLES = 8,
    parameter int unsigned MAX_BEEPS       = 6
) (
    input logic                    clk,
    input logic                    reset,
    car_alarm_annunciator_if.slave alarm_bus
);

    typedef enum logic [2:0] {IDLE, QUALIFY, BEEP_ON, BEEP_OFF, SILENCED} state_e;

    localparam logic [3:0] DebLast  = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] OnLast   = 8'(BEEP_ON_CYCLES - 1);
    localparam logic [7:0] OffLast  = 8'(BEEP_OFF_CYCLES - 1);
    localparam logic [3:0] MaxBeeps = 4'(MAX_BEEPS);

    state_e     r_state, w_state_d;
    logic [3:0] r_deb, w_deb_d;
    logic [7:0] r_timer, w_timer_d;
    logic [3:0] r_beeps, w_beeps_d;

    logic       w_alarm, w_silence;
    logic       w_buzzer, w_lamp, w_active;

    assign w_alarm   = alarm_bus.CarAlarmSignal;
    assign w_silence = alarm_bus.SilenceButton;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_deb   <= 4'd0;
            r_timer <= 8'd0;
            r_beeps <= 4'd0;
        end else begin
            r_state <= w_state_d;
            r_deb   <= w_deb_d;
            r_timer <= w_timer_d;
            r_beeps <= w_beeps_d;
        end
    end

    // Alarm drop outranks the silence button in every annunciating state.
    always_comb begin
        w_state_d = r_state;
        w_deb_d   = r_deb;
        w_timer_d = r_timer;
        w_beeps_d = r_beeps;
        unique case (r_state)
            IDLE: begin
                if (w_alarm) begin
                    w_state_d = QUALIFY;
                    w_deb_d   = 4'd1;
                end
            end
            QUALIFY: begin
                if (!w_alarm) begin
                    w_state_d = IDLE;
                    w_deb_d   = 4'd0;
                end else if (r_deb == DebLast) begin
                    w_state_d = BEEP_ON;
                    w_deb_d   = 4'd0;
                    w_timer_d = 8'd0;
                end else begin
                    w_deb_d = r_deb + 4'd1;
                end
            end
            BEEP_ON: begin
                if (!w_alarm) begin
                    w_state_d = IDLE;
                    w_timer_d = 8'd0;
                    w_beeps_d = 4'd0;
                end else if (w_silence) begin
                    w_state_d = SILENCED;
                    w_timer_d = 8'd0;
                end else if (r_timer == OnLast) begin
                    w_state_d = BEEP_OFF;
                    w_timer_d = 8'd0;
                    if (r_beeps < MaxBeeps) begin
                        w_beeps_d = r_beeps + 4'd1;
                    end
                end else begin
                    w_timer_d = r_timer + 8'd1;
                end
            end
            BEEP_OFF: begin
                if (!w_alarm) begin
                    w_state_d = IDLE;
                    w_timer_d = 8'd0;
                    w_beeps_d = 4'd0;
                end else if (w_silence) begin
                    w_state_d = SILENCED;
                    w_timer_d = 8'd0;
                end else if (r_timer == OffLast) begin
                    w_state_d = (r_beeps >= MaxBeeps) ? SILENCED : BEEP_ON;
                    w_timer_d = 8'd0;
                end else begin
                    w_timer_d = r_timer + 8'd1;
                end
            end
            SILENCED: begin
                if (!w_alarm) begin
                    w_state_d = IDLE;
                    w_timer_d = 8'd0;
                    w_beeps_d = 4'd0;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_deb_d   = 4'd0;
                w_timer_d = 8'd0;
                w_beeps_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_buzzer = 1'b0;
        w_lamp   = 1'b0;
        w_active = 1'b0;
        unique case (r_state)
            BEEP_ON: begin
                w_buzzer = 1'b1;
                w_lamp   = 1'b1;
                w_active = 1'b1;
            end
            BEEP_OFF: begin
                w_active = 1'b1;
            end
            SILENCED: begin
                w_lamp   = 1'b1;
                w_active = 1'b1;
            end
            default: begin
                w_buzzer = 1'b0;
            end
        endcase
    end

    assign alarm_bus.BuzzerOut   = w_buzzer;
    assign alarm_bus.WarningLamp = w_lamp;
    assign alarm_bus.AlarmActive = w_active;
    assign alarm_bus.BeepCount   = r_beeps;

endmodule

// File: tb/tb_car_alarm_annunciator.sv
// Directed bench for car_alarm_annunciator with default parameters.
module tb_car_alarm_annunciator;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    car_alarm_annunciator_if u_if();

    car_alarm_annunciator #(
        .DEBOUNCE_CYCLES(4),
        .BEEP_ON_CYCLES (8),
        .BEEP_OFF_CYCLES(8),
        .MAX_BEEPS      (6)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .alarm_bus(u_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic buz, input logic lamp, input logic act,
                       input logic [3:0] cnt);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {u_if.BuzzerOut, u_if.WarningLamp, u_if.AlarmActive, u_if.BeepCount};
        exp = {buz, lamp, act, cnt};
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (buz,lamp,act,cnt)", tag, obs, exp);
        end
    endtask

    initial begin
        int m;
        int ph;
        int k;
        reset                = 1'b1;
        u_if.CarAlarmSignal  = 1'b0;
        u_if.SilenceButton   = 1'b0;
        #2;
        chk("reset_state", 0, 0, 0, 4'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle_after_reset", 0, 0, 0, 4'd0);

        // Short pulse: three highs never qualify.
        u_if.CarAlarmSignal = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("short_q%0d", i), 0, 0, 0, 4'd0);
        end
        u_if.CarAlarmSignal = 1'b0;
        tick();
        chk("short_drop", 0, 0, 0, 4'd0);
        tick();
        chk("short_idle", 0, 0, 0, 4'd0);

        // Full episode to auto-silence.
        u_if.CarAlarmSignal = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("full_q%0d", i), 0, 0, 0, 4'd0);
        end
        tick();
        chk("full_first_on", 1, 1, 1, 4'd0);
        for (int n = 5; n <= 110; n++) begin
            tick();
            m = n - 4;
            if (m < 96) begin
                k  = m / 16;
                ph = m % 16;
                if (ph < 8) chk($sformatf("full_e%0d", n), 1, 1, 1, 4'(k));
                else        chk($sformatf("full_e%0d", n), 0, 0, 1, 4'(k + 1));
            end else begin
                chk($sformatf("full_e%0d", n), 0, 1, 1, 4'd6);
            end
        end
        u_if.CarAlarmSignal = 1'b0;
        tick();
        chk("full_drop", 0, 0, 0, 4'd0);

        // Silence during beep 2; button held through qualify is ignored.
        u_if.CarAlarmSignal = 1'b1;
        u_if.SilenceButton  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("sil_q%0d", i), 0, 0, 0, 4'd0);
        end
        tick();
        chk("sil_first_on", 1, 1, 1, 4'd0);
        u_if.SilenceButton = 1'b0;
        for (int i = 5; i <= 21; i++) tick();
        chk("sil_beep2", 1, 1, 1, 4'd1);
        u_if.SilenceButton = 1'b1;
        tick();
        chk("sil_enter", 0, 1, 1, 4'd1);
        u_if.SilenceButton = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("sil_hold%0d", i), 0, 1, 1, 4'd1);
        end
        u_if.SilenceButton = 1'b1;
        tick();
        chk("sil_repress", 0, 1, 1, 4'd1);
        u_if.SilenceButton  = 1'b0;
        u_if.CarAlarmSignal = 1'b0;
        tick();
        chk("sil_exit", 0, 0, 0, 4'd0);

        // Drop and silence on the same edge: drop wins.
        u_if.CarAlarmSignal = 1'b1;
        for (int i = 1; i <= 4; i++) tick();
        chk("prio_on", 1, 1, 1, 4'd0);
        tick();
        tick();
        chk("prio_mid", 1, 1, 1, 4'd0);
        u_if.CarAlarmSignal = 1'b0;
        u_if.SilenceButton  = 1'b1;
        tick();
        chk("prio_idle", 0, 0, 0, 4'd0);
        tick();
        chk("prio_sil_ignored", 0, 0, 0, 4'd0);
        u_if.SilenceButton = 1'b0;

        // Asynchronous reset mid-beep, then full re-qualification.
        u_if.CarAlarmSignal = 1'b1;
        for (int i = 1; i <= 4; i++) tick();
        chk("rst_on", 1, 1, 1, 4'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("rst_mid", 1, 1, 1, 4'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async", 0, 0, 0, 4'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_held", 0, 0, 0, 4'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("rst_q%0d", i), 0, 0, 0, 4'd0);
        end
        tick();
        chk("rst_reon", 1, 1, 1, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/car_alarm_annunciator.md
CAR_ALARM_ANNUNCIATOR -- requirements
Module: car_alarm_annunciator

Interface
REQ-001 The block SHALL use one clock and one reset: the clock is clk, and the reset is reset, which is asynchronous and active-high.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive high samples of CarAlarmSignal required before annunciation; legal range 2..15.
REQ-003 The block SHALL have parameter BEEP_ON_CYCLES, default 8: BuzzerOut high time per beep; legal range 1..255.
REQ-004 The block SHALL have parameter BEEP_OFF_CYCLES, default 8: BuzzerOut low time between beeps; legal range 1..255.
REQ-005 The block SHALL have parameter MAX_BEEPS, default 6: beeps issued before auto-silence; legal range 1..15.
REQ-006 Port clk: input, 1 bit, rising-edge clock.
REQ-007 Port reset: input, 1 bit, asynchronous active-high reset.
REQ-008 Port CarAlarmSignal: input, 1 bit, alarm request from the alarm detector (lights on, door open, ignition off).
REQ-009 Port SilenceButton: input, 1 bit, driver acknowledge; level-sampled on clk.
REQ-010 Port BuzzerOut: output, 1 bit, buzzer drive.
REQ-011 Port WarningLamp: output, 1 bit, dash lamp.
REQ-012 Port AlarmActive: output, 1 bit, high while annunciating or silenced.
REQ-013 Port BeepCount: output, 4 bits, completed beeps in the current episode.

Function
REQ-014 The block SHALL implement a state machine with exactly these states: IDLE, QUALIFY, BEEP_ON, BEEP_OFF, SILENCED.
REQ-015 All outputs SHALL be registered and decoded from state or registers only (Moore), with no combinational path from inputs to outputs.
REQ-016 In IDLE, a CarAlarmSignal=1 sample SHALL move the machine to QUALIFY with debounce count 1.
REQ-017 In QUALIFY, CarAlarmSignal=0 on any edge SHALL return the machine to IDLE and clear the debounce count; no output changes.
REQ-018 In QUALIFY, on the DEBOUNCE_CYCLES-th consecutive high sample the machine SHALL enter BEEP_ON; BuzzerOut goes high in the cycle after that edge.
REQ-019 In BEEP_ON, BuzzerOut=1 for exactly BEEP_ON_CYCLES cycles, after which the machine SHALL enter BEEP_OFF and increment BeepCount on the same edge.
REQ-020 In BEEP_OFF, BuzzerOut=0 for exactly BEEP_OFF_CYCLES cycles; then, if BeepCount==MAX_BEEPS, the machine SHALL enter SILENCED, else BEEP_ON.
REQ-021 WarningLamp SHALL equal BuzzerOut in BEEP_ON and BEEP_OFF, and SHALL be steady 1 in SILENCED.
REQ-022 AlarmActive SHALL be 1 in BEEP_ON, BEEP_OFF and SILENCED, and 0 in IDLE and QUALIFY.
REQ-023 In BEEP_ON or BEEP_OFF, SilenceButton=1 SHALL cause entry to SILENCED on that edge; BuzzerOut is 0 from the next cycle and BeepCount holds.
REQ-024 In BEEP_ON, BEEP_OFF or SILENCED, CarAlarmSignal=0 SHALL cause entry to IDLE on that edge, clearing BeepCount and all outputs.
REQ-025 When CarAlarmSignal=0 and SilenceButton=1 on the same edge, the CarAlarmSignal drop SHALL take priority and the next state is IDLE.
REQ-026 SILENCED SHALL persist while CarAlarmSignal=1 regardless of SilenceButton; only a CarAlarmSignal drop or reset exits it.
REQ-027 SilenceButton SHALL be ignored in IDLE and QUALIFY.
REQ-028 BeepCount SHALL saturate at MAX_BEEPS and never wrap.
REQ-029 Beep cycle counters SHALL be 8 bits, reload on every state entry, and be unaffected by BeepCount.

Reset
REQ-030 Reset assertion SHALL immediately and asynchronously force IDLE, BuzzerOut=0, WarningLamp=0, AlarmActive=0, BeepCount=0 and all counters to 0, including mid-beep.
REQ-031 After reset deassertion, the first qualifying episode SHALL require a full DEBOUNCE_CYCLES of high samples counted from the first post-reset edge.

Verification
REQ-032 With default parameters, raise CarAlarmSignal for 3 cycles then drop it -> BuzzerOut, AlarmActive and BeepCount stay 0 throughout.
REQ-033 Hold CarAlarmSignal=1 -> BuzzerOut rises in the cycle after the 4th high sample; pattern is 8 high / 8 low; after 6 beeps the block is in SILENCED with BeepCount=6, WarningLamp=1 and BuzzerOut=0.
REQ-034 Hold CarAlarmSignal=1 and pulse SilenceButton during beep 2 -> BuzzerOut=0 from the next cycle, BeepCount=1, WarningLamp=1 steady, AlarmActive=1.
REQ-035 Drop CarAlarmSignal in the same cycle SilenceButton=1, during BEEP_ON -> next state is IDLE with all outputs 0 and BeepCount=0.
REQ-036 Assert reset for one cycle in the middle of BEEP_ON -> all outputs 0 immediately without waiting for clk; with CarAlarmSignal still high, BuzzerOut re-rises in the cycle after the 4th post-reset high sample.
